// File: rtl/fpu_ss_core_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_ss_core_arbiter
//
// Shares one fpu_ss offload port between NB_CORES cluster cores.
// The arbiter picks one issue request per cycle. Grants are round-robin by
// default. An offered grant stays locked until the subsystem accepts it.
// Per-core outstanding counters throttle each core. Results are steered back
// to their owner by core ID.
//
// Build option:
//   FPU_SS_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest eligible
//                                          index wins, no rr pointer
//                             undefined -> round-robin from the rr pointer
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   core_issue_*             per-core issue request/accept/payload
//   ss_issue_*, ss_core_id_o granted request towards the subsystem
//   ss_result_*              result stream from the subsystem
//   core_result_*            routed result valid / per-core ready
//   outstanding_o            4-bit in-flight count per core
//   err_o                    sticky protocol error (cleared by reset only)
// ---------------------------------------------------------------------------
module fpu_ss_core_arbiter #(
    parameter int NB_CORES        = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_CORES-1:0]            core_issue_valid_i,
    output logic [NB_CORES-1:0]            core_issue_ready_o,
    input  logic [NB_CORES*DATA_WIDTH-1:0] core_issue_data_i,
    output logic                           ss_issue_valid_o,
    input  logic                           ss_issue_ready_i,
    output logic [DATA_WIDTH-1:0]          ss_issue_data_o,
    output logic [31:0]                    ss_core_id_o,
    input  logic                           ss_result_valid_i,
    input  logic [31:0]                    ss_result_core_id_i,
    output logic                           ss_result_ready_o,
    output logic [NB_CORES-1:0]            core_result_valid_o,
    input  logic [NB_CORES-1:0]            core_result_ready_i,
    output logic [NB_CORES*4-1:0]          outstanding_o,
    output logic                           err_o
);

    localparam int              IW       = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NB_CORES - 1);

    logic [NB_CORES-1:0][3:0]   cnt_q, cnt_d;
    logic                       lock_q, lock_d;
    logic [IW-1:0]              lock_idx_q, lock_idx_d;
    logic                       err_q, err_d;

    logic [NB_CORES-1:0]        eligible;
    logic [NB_CORES-1:0]        cnt_inc, cnt_dec;
    logic [DATA_WIDTH-1:0]      payload [NB_CORES];
    logic [IW-1:0]              arb_grant, grant;
    logic                       issue_valid, issue_hs, lock_drop;
    logic [IW-1:0]              res_idx;
    logic                       res_id_ok, res_cnt_zero, res_bad, res_hs;

    // -----------------------------------------------------------------------
    // Per-core eligibility, payload unpacking, counters and routed valids
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
        assign eligible[gi]   = core_issue_valid_i[gi] & (cnt_q[gi] < MAX_CNT);
        assign payload[gi]    = core_issue_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign outstanding_o[gi*4 +: 4] = cnt_q[gi];

        assign cnt_inc[gi] = issue_hs & (grant == IW'(gi));
        assign cnt_dec[gi] = res_hs & (res_idx == IW'(gi));

        assign core_issue_ready_o[gi]  = rst_ni & issue_hs & (grant == IW'(gi));
        assign core_result_valid_o[gi] = rst_ni & ss_result_valid_i & ~res_bad
                                         & res_id_ok & (res_idx == IW'(gi));

        // A simultaneous issue and result on the same core cancel out.
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (cnt_inc[gi] && !cnt_dec[gi]) begin
                cnt_d[gi] = cnt_q[gi] + 4'd1;
            end else if (cnt_dec[gi] && !cnt_inc[gi]) begin
                cnt_d[gi] = cnt_q[gi] - 4'd1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q[gi] <= 4'd0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration (used only while no grant is locked)
    // -----------------------------------------------------------------------
`ifdef FPU_SS_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest eligible index is the last write.
    always_comb begin
        arb_grant = '0;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            if (eligible[IW'(i)]) begin
                arb_grant = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] rr_q, rr_d;

    // Scan offsets from farthest to nearest, so the first eligible core at
    // or after rr_q is the last write. The index wraps without a modulo.
    always_comb begin
        int idx;
        idx       = 0;
        arb_grant = rr_q;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NB_CORES) begin
                idx = idx - NB_CORES;
            end
            if (eligible[idx[IW-1:0]]) begin
                arb_grant = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (issue_hs) begin
            rr_d = (grant == LAST_IDX) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Issue path. While locked, the valid follows the locked core live. A
    // dropped valid is a protocol error and retracts the request.
    // -----------------------------------------------------------------------
    assign grant       = lock_q ? lock_idx_q : arb_grant;
    assign issue_valid = lock_q ? core_issue_valid_i[lock_idx_q] : (|eligible);
    assign lock_drop   = lock_q & ~core_issue_valid_i[lock_idx_q];
    assign issue_hs    = issue_valid & ss_issue_ready_i;

    assign ss_issue_valid_o = rst_ni & issue_valid;
    assign ss_issue_data_o  = rst_ni ? payload[grant] : '0;
    assign ss_core_id_o     = rst_ni ? 32'(grant) : 32'd0;

    // -----------------------------------------------------------------------
    // Result path. Results with an unknown owner, or for a core with nothing
    // in flight, are accepted and dropped so that the subsystem never stalls.
    // -----------------------------------------------------------------------
    assign res_id_ok    = ss_result_core_id_i < 32'(NB_CORES);
    assign res_idx      = ss_result_core_id_i[IW-1:0];
    assign res_cnt_zero = res_id_ok && (cnt_q[res_idx] == 4'd0);
    assign res_bad      = ss_result_valid_i & (~res_id_ok | res_cnt_zero);
    assign res_hs       = ss_result_valid_i & ~res_bad & core_result_ready_i[res_idx];

    assign ss_result_ready_o = rst_ni & (~res_id_ok | res_bad | core_result_ready_i[res_idx]);

    // -----------------------------------------------------------------------
    // Lock and error state
    // -----------------------------------------------------------------------
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | res_bad;
        if (issue_hs) begin
            lock_d = 1'b0;
        end else if (lock_drop) begin
            lock_d = 1'b0;
            err_d  = 1'b1;
        end else if (issue_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for fpu_ss_core_arbiter (NB_CORES=4, DATA_WIDTH=16,
// MAX_OUTSTANDING=3). It runs directed scenarios and then a randomized run.
// The randomized run is checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_fpu_ss_core_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int MAX = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      civ, cir;
    logic [N*DW-1:0]   cid;
    logic              siv, sir;
    logic [DW-1:0]     sid;
    logic [31:0]       scid;
    logic              srv;
    logic [31:0]       srcid;
    logic              srr;
    logic [N-1:0]      crv, crr;
    logic [N*4-1:0]    outst;
    logic              err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_ss_core_arbiter #(
        .NB_CORES(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .core_issue_valid_i  (civ),
        .core_issue_ready_o  (cir),
        .core_issue_data_i   (cid),
        .ss_issue_valid_o    (siv),
        .ss_issue_ready_i    (sir),
        .ss_issue_data_o     (sid),
        .ss_core_id_o        (scid),
        .ss_result_valid_i   (srv),
        .ss_result_core_id_i (srcid),
        .ss_result_ready_o   (srr),
        .core_result_valid_o (crv),
        .core_result_ready_i (crr),
        .outstanding_o       (outst),
        .err_o               (err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        civ = '0; cid = '0; sir = 1'b0; srv = 1'b0; srcid = '0; crr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        checks++; if (siv !== 1'b0) begin failures++; $display("FAIL reset_siv got=%0b exp=0", siv); end
        checks++; if (outst !== '0) begin failures++; $display("FAIL reset_outst got=%h exp=0", outst); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (srr !== 1'b0 || cir !== '0 || crv !== '0) begin
            failures++; $display("FAIL reset_ready got srr=%0b cir=%b crv=%b exp=0", srr, cir, crv);
        end
        rst_n = 1'b1;
        #1;
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        int prev;
        do_reset();
        civ = '1; sir = 1'b1; crr = '1; prev = 0;
        for (int i = 0; i < 6; i++) begin
            cid = {$urandom, $urandom};
            srv = (i > 0); srcid = 32'(prev);
            #1;
            checks++; if (scid !== 32'(i % N) || cir !== (4'b1 << (i % N))) begin
                failures++; $display("FAIL rr_grant[%0d] got id=%0d rdy=%b exp id=%0d", i, scid, cir, i % N);
            end
            checks++; if (sid !== cid[(i % N)*DW +: DW]) begin
                failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, sid, cid[(i % N)*DW +: DW]);
            end
            prev = i % N;
            cyc();
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rr_err got=%0b exp=0", err); end
        $display("test_round_robin done");
    endtask

    task automatic test_lock();
        logic [DW-1:0] d2;
        do_reset();
        civ = 4'b0100; sir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) civ = 4'b0110;
            d2 = DW'($urandom);
            cid = {DW'($urandom), d2, DW'($urandom), DW'($urandom)};
            #1;
            checks++; if (siv !== 1'b1 || scid !== 32'd2 || sid !== d2 || cir !== '0) begin
                failures++; $display("FAIL lock_hold[%0d] got v=%0b id=%0d d=%h rdy=%b exp v=1 id=2 d=%h rdy=0",
                                     i, siv, scid, sid, cir, d2);
            end
            cyc();
        end
        sir = 1'b1;
        #1;
        checks++; if (cir !== 4'b0100 || scid !== 32'd2) begin
            failures++; $display("FAIL lock_release got id=%0d rdy=%b exp id=2 rdy=0100", scid, cir);
        end
        cyc();
        checks++; if (scid !== 32'd1 || cir !== 4'b0010) begin
            failures++; $display("FAIL lock_wrap got id=%0d rdy=%b exp id=1 rdy=0010", scid, cir);
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL lock_err got=%0b exp=0", err); end
        $display("test_lock done");
    endtask

    task automatic test_throttle();
        do_reset();
        civ = 4'b0001; sir = 1'b1;
        repeat (MAX) cyc();
        srv = 1'b1; srcid = 32'd0; crr = 4'b0001;
        #1;
        checks++; if (cir !== '0 || siv !== 1'b0) begin
            failures++; $display("FAIL throttle_mask got rdy=%b v=%0b exp 0", cir, siv);
        end
        checks++; if (outst[3:0] !== 4'(MAX)) begin
            failures++; $display("FAIL throttle_cnt got=%0d exp=%0d", outst[3:0], MAX);
        end
        checks++; if (crv !== 4'b0001 || srr !== 1'b1) begin
            failures++; $display("FAIL throttle_result got crv=%b srr=%0b exp 0001/1", crv, srr);
        end
        cyc();
        srv = 1'b0;
        #1;
        checks++; if (cir !== 4'b0001 || scid !== 32'd0) begin
            failures++; $display("FAIL throttle_regrant got rdy=%b id=%0d exp 0001/0", cir, scid);
        end
        $display("test_throttle done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        civ = 4'b0010; sir = 1'b1;
        cyc();
        srv = 1'b1; srcid = 32'd1; crr = 4'b0010;
        #1;
        checks++; if (cir !== 4'b0010 || srr !== 1'b1 || crv !== 4'b0010) begin
            failures++; $display("FAIL simul_hs got rdy=%b srr=%0b crv=%b exp 0010/1/0010", cir, srr, crv);
        end
        cyc();
        idle_inputs();
        #1;
        checks++; if (outst !== 16'h0010) begin
            failures++; $display("FAIL simul_cnt got=%h exp=0010", outst);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_bad_result();
        do_reset();
        srv = 1'b1; srcid = 32'd9; crr = '1;
        #1;
        checks++; if (srr !== 1'b1 || crv !== '0 || err !== 1'b0) begin
            failures++; $display("FAIL badid_comb got srr=%0b crv=%b err=%0b exp 1/0/0", srr, crv, err);
        end
        cyc();
        srv = 1'b0;
        repeat (2) cyc();
        checks++; if (err !== 1'b1 || outst !== '0) begin
            failures++; $display("FAIL badid_err got err=%0b outst=%h exp 1/0", err, outst);
        end
        do_reset();
        srv = 1'b1; srcid = 32'd2; crr = '0;
        #1;
        checks++; if (srr !== 1'b1 || crv !== '0) begin
            failures++; $display("FAIL zerocnt_comb got srr=%0b crv=%b exp 1/0", srr, crv);
        end
        cyc();
        srv = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || outst !== '0) begin
            failures++; $display("FAIL zerocnt_err got err=%0b outst=%h exp 1/0", err, outst);
        end
        $display("test_bad_result done");
    endtask

    task automatic test_lock_drop();
        do_reset();
        civ = 4'b0001; sir = 1'b0;
        cyc();
        civ = 4'b0000;
        #1;
        checks++; if (siv !== 1'b0 || cir !== '0) begin
            failures++; $display("FAIL drop_valid got v=%0b rdy=%b exp 0/0", siv, cir);
        end
        cyc();
        civ = 4'b0010; sir = 1'b1;
        #1;
        checks++; if (err !== 1'b1 || scid !== 32'd1 || cir !== 4'b0010) begin
            failures++; $display("FAIL drop_after got err=%0b id=%0d rdy=%b exp 1/1/0010", err, scid, cir);
        end
        $display("test_lock_drop done");
    endtask

    task automatic test_reset_while_locked();
        do_reset();
        civ = 4'b1000; sir = 1'b1;
        repeat (2) cyc();
        sir = 1'b0;
        cyc();
        #1;
        checks++; if (outst[15:12] !== 4'd2 || siv !== 1'b1 || scid !== 32'd3) begin
            failures++; $display("FAIL rstlock_pre got cnt3=%0d v=%0b id=%0d exp 2/1/3", outst[15:12], siv, scid);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (siv !== 1'b0 || cir !== '0 || outst !== '0 || err !== 1'b0 || scid !== '0) begin
            failures++; $display("FAIL rstlock_async got v=%0b rdy=%b outst=%h err=%0b id=%0d exp all 0",
                                 siv, cir, outst, err, scid);
        end
        cyc();
        rst_n = 1'b1;
        civ = '1; sir = 1'b1;
        #1;
        checks++; if (scid !== 32'd0 || cir !== 4'b0001) begin
            failures++; $display("FAIL rstlock_first got id=%0d rdy=%b exp 0/0001", scid, cir);
        end
        $display("test_reset_while_locked done");
    endtask

    // Randomized traffic against a reference model of the arbiter's rules.
    task automatic test_random();
        int  m_cnt [N];
        int  m_rr, m_lc, g, id, k0, mism0;
        bit  m_lock, m_err, v, okid, bad, ihs, rhs;
        logic [N-1:0]   e_cir, e_crv;
        logic [N*4-1:0] e_out;
        logic           e_srr;
        do_reset();
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_rr = 0; m_lc = 0; m_lock = 0; m_err = 0;
        mism0 = failures;
        for (int t = 0; t < 400; t++) begin
            civ = N'($urandom);
            sir = ($urandom_range(0, 3) != 0);
            cid = {$urandom, $urandom};
            crr = N'($urandom);
            srv = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 31) == 0) begin
                srcid = $urandom_range(N, 40);
            end else begin
                k0 = $urandom_range(0, N - 1);
                srcid = 32'(k0);
                for (int j = 0; j < N; j++)
                    if (m_cnt[(k0 + j) % N] > 0 && srcid == 32'(k0)) srcid = 32'((k0 + j) % N);
            end
            #1;
            // Expected issue side.
            v = 0; g = 0;
            if (m_lock) begin
                g = m_lc; v = civ[g];
            end else begin
                for (int off = N - 1; off >= 0; off--) begin
                    if (civ[(m_rr + off) % N] && m_cnt[(m_rr + off) % N] < MAX) begin
                        g = (m_rr + off) % N; v = 1;
                    end
                end
            end
            ihs   = v && sir;
            e_cir = ihs ? N'(1 << g) : '0;
            // Expected result side.
            okid  = srcid < N;
            id    = okid ? int'(srcid) : 0;
            bad   = srv && (!okid || m_cnt[id] == 0);
            e_crv = (srv && !bad) ? N'(1 << id) : '0;
            e_srr = !okid || bad || crr[id];
            rhs   = srv && !bad && crr[id];
            for (int k = 0; k < N; k++) e_out[k*4 +: 4] = 4'(m_cnt[k]);

            checks++; if (siv !== v || cir !== e_cir) begin
                failures++; $display("FAIL rnd_issue[%0d] got v=%0b rdy=%b exp v=%0b rdy=%b", t, siv, cir, v, e_cir);
            end
            if (v) begin
                checks++; if (scid !== 32'(g) || sid !== cid[g*DW +: DW]) begin
                    failures++; $display("FAIL rnd_data[%0d] got id=%0d d=%h exp id=%0d d=%h",
                                         t, scid, sid, g, cid[g*DW +: DW]);
                end
            end
            checks++; if (crv !== e_crv || srr !== e_srr) begin
                failures++; $display("FAIL rnd_result[%0d] got crv=%b srr=%0b exp crv=%b srr=%0b", t, crv, srr, e_crv, e_srr);
            end
            checks++; if (outst !== e_out || err !== m_err) begin
                failures++; $display("FAIL rnd_state[%0d] got outst=%h err=%0b exp outst=%h err=%0b", t, outst, err, e_out, m_err);
            end
            // Advance the model.
            if (ihs) begin
                m_cnt[g]++; m_rr = (g + 1) % N; m_lock = 0;
            end else if (m_lock && !civ[g]) begin
                m_lock = 0; m_err = 1;
            end else if (v) begin
                m_lock = 1; m_lc = g;
            end
            if (rhs) m_cnt[id]--;
            if (bad) m_err = 1;
            cyc();
        end
        $display("test_random done errors=%0d", failures - mism0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_lock();
        test_throttle();
        test_simultaneous();
        test_bad_result();
        test_lock_drop();
        test_reset_while_locked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
